// File: rtl/lfsr_bist_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_bist_ctrl
//
// BIST sequencer for an external LFSR pattern generator. A run seeds the
// LFSR and steps it for n_patterns cycles, or for one full period when
// n_patterns is 0. Each cycle the response of the circuit under test is
// compacted into an internal Galois MISR. The final signature is compared
// against a golden value.
//
// Optional build macro:
//   BIST_LOCKUP_DET_EN - adds output 'lockup'. An all-zero LFSR state ends
//                        the run without compacting that pattern, and the
//                        run is reported as failing.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-low reset
//   start          in   one-cycle run request; ignored while busy or done
//   seed_in        in   LFSR seed (0 is replaced by 1), latched on start
//   n_patterns     in   pattern count, latched on start; 0 = period mode
//   golden         in   expected signature, latched on start
//   lfsr_q         in   current LFSR state
//   dut_resp       in   CUT response to lfsr_q, in the same cycle
//   lfsr_load      out  load lfsr_seed into the LFSR at the next edge
//   lfsr_seed      out  seed presented to the LFSR
//   lfsr_en        out  step the LFSR at the next edge
//   busy           out  high in LOAD, RUN and COMPARE
//   done           out  one-cycle completion pulse
//   pass           out  signature matched golden (held until next start)
//   timeout        out  period mode hit the 2^WIDTH cap (held)
//   signature      out  final MISR value (held)
//   pattern_count  out  number of patterns compacted (held)
//   lockup         out  (BIST_LOCKUP_DET_EN only) zero state seen (held)
// ---------------------------------------------------------------------------
module lfsr_bist_ctrl #(
  parameter int               WIDTH     = 4,
  parameter int               CNT_WIDTH = WIDTH + 1,
  parameter logic [WIDTH-1:0] MISR_TAPS = WIDTH'(4'b0011)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     seed_in,
  input  logic [CNT_WIDTH-1:0] n_patterns,
  input  logic [WIDTH-1:0]     golden,
  input  logic [WIDTH-1:0]     lfsr_q,
  input  logic [WIDTH-1:0]     dut_resp,
  output logic                 lfsr_load,
  output logic [WIDTH-1:0]     lfsr_seed,
  output logic                 lfsr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [WIDTH-1:0]     signature,
  output logic [CNT_WIDTH-1:0] pattern_count
`ifdef BIST_LOCKUP_DET_EN
  ,
  output logic                 lockup
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_COMPARE,
    S_DONE
  } state_t;

  // Count value of the last pattern before the period-mode cap of 2^WIDTH.
  localparam logic [CNT_WIDTH-1:0] CAP_LAST = CNT_WIDTH'((1 << WIDTH) - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               state;
  logic [WIDTH-1:0]     seed_q;
  logic [CNT_WIDTH-1:0] n_q;
  logic [WIDTH-1:0]     golden_q;
  logic [WIDTH-1:0]     misr;
  logic [CNT_WIDTH-1:0] count;

  logic period_mode;
  logic seed_hit;
  logic lock_hit;
  logic lock_flag;
  logic stop_hold;
  logic last_pat;

  // The all-zero state locks the LFSR, so it is never used as a seed.
  function automatic logic [WIDTH-1:0] fix_seed(input logic [WIDTH-1:0] s);
    return (s == '0) ? WIDTH'(1) : s;
  endfunction

  // One Galois MISR step: shift left, fold the MSB back through the taps,
  // and absorb the current response.
  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] m,
                                                 input logic [WIDTH-1:0] resp);
    return {m[WIDTH-2:0], 1'b0} ^ (m[WIDTH-1] ? MISR_TAPS : '0) ^ resp;
  endfunction

  assign period_mode = (n_q == '0);

  // In period mode the run ends when the seed comes back around; that
  // repeated pattern is neither compacted nor stepped past.
  assign seed_hit = period_mode && (count != '0) && (lfsr_q == seed_q);

`ifdef BIST_LOCKUP_DET_EN
  assign lock_hit  = (lfsr_q == '0);
  assign lock_flag = lockup;
`else
  assign lock_hit  = 1'b0;
  assign lock_flag = 1'b0;
`endif

  // Cycles that end the run without compacting the current pattern.
  assign stop_hold = seed_hit || lock_hit;

  // Last compacted pattern: count reaches n_patterns, or the period cap.
  assign last_pat = period_mode ? (count == CAP_LAST) : (count == (n_q - CNT_ONE));

  // lfsr_en depends on the same-cycle lfsr_q, so it is decoded rather than
  // registered; gating by state keeps it low during and right after reset.
  assign lfsr_en   = (state == S_RUN) && !stop_hold;
  assign lfsr_seed = seed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      lfsr_load     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      signature     <= '0;
      pattern_count <= '0;
      seed_q        <= '0;
      n_q           <= '0;
      golden_q      <= '0;
      misr          <= '0;
      count         <= '0;
`ifdef BIST_LOCKUP_DET_EN
      lockup        <= 1'b0;
`endif
    end else begin
      lfsr_load <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            seed_q        <= fix_seed(seed_in);
            n_q           <= n_patterns;
            golden_q      <= golden;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            signature     <= '0;
            pattern_count <= '0;
`ifdef BIST_LOCKUP_DET_EN
            lockup        <= 1'b0;
`endif
            lfsr_load     <= 1'b1;
            busy          <= 1'b1;
            state         <= S_LOAD;
          end
        end

        // LFSR takes the seed at the end of this cycle
        S_LOAD: begin
          misr  <= '0;
          count <= '0;
          state <= S_RUN;
        end

        // one pattern per cycle
        S_RUN: begin
          if (stop_hold) begin
`ifdef BIST_LOCKUP_DET_EN
            lockup <= lock_hit;
`endif
            state <= S_COMPARE;
          end else begin
            misr  <= misr_step(misr, dut_resp);
            count <= count + CNT_ONE;
            if (period_mode && (count == CAP_LAST)) begin
              timeout <= 1'b1;
            end
            if (last_pat) begin
              state <= S_COMPARE;
            end
          end
        end

        // publish results
        S_COMPARE: begin
          signature     <= misr;
          pattern_count <= count;
          pass          <= (misr == golden_q) && !timeout && !lock_flag;
          busy          <= 1'b0;
          done          <= 1'b1;
          state         <= S_DONE;
        end

        // done pulse; a start here is deliberately not accepted
        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
